// File: rtl/posit_operand_decoder.sv
// Two-stage posit operand decoder feeding a divider core: stage 1 captures sign,
// special flags and magnitude; stage 2 extracts regime/exponent/fraction.
module posit_operand_decoder #(
  parameter int N  = 32,
  parameter int ES = 2,
  localparam int SW = $clog2(N) + ES + 1,
  localparam int FW = N - ES - 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  IN1,
  input  logic [N-1:0]  IN2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          A_sign,
  output logic          B_sign,
  output logic          A_zero,
  output logic          B_zero,
  output logic          A_nar,
  output logic          B_nar,
  output logic [SW-1:0] A_scale,
  output logic [SW-1:0] B_scale,
  output logic [FW-1:0] A_frac,
  output logic [FW-1:0] B_frac
);

  localparam int MW = $clog2(N) + 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Magnitude of a non-NaR posit always has a zero MSB, so only N-1 bits are kept.
  // The run occupies at least one bit plus its terminator, hence the remainder
  // starts at bit N-4 and is shifted by the extra run length (m-1).
  function automatic logic [SW+FW-1:0] decode(input logic [N-2:0] body);
    logic          rb;
    logic          run;
    logic [MW-1:0] m;
    logic [N-4:0]  sh;
    logic [SW-1:0] k;
    rb  = body[N-2];
    run = 1'b1;
    m   = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == rb)) m = m + MW'(1);
      else run = 1'b0;
    end
    sh = body[N-4:0] << (m - MW'(1));
    k  = rb ? (SW'(m) - SW'(1)) : -SW'(m);
    return {(k << ES) + SW'(sh[N-4 -: ES]), 1'b1, sh[N-4-ES:0]};
  endfunction

  logic          s1_valid;
  logic          s1_a_sign, s1_a_zero, s1_a_nar;
  logic          s1_b_sign, s1_b_zero, s1_b_nar;
  logic [N-2:0]  s1_a_mag, s1_b_mag;
  logic [SW+FW-1:0] dec_a, dec_b;
  logic          s1_load, s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    dec_a = decode(s1_a_mag);
    dec_b = decode(s1_b_mag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a_sign <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_a_nar  <= 1'b0;
      s1_a_mag  <= '0;
      s1_b_sign <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_b_nar  <= 1'b0;
      s1_b_mag  <= '0;
    end else if (s1_load) begin
      s1_valid  <= in_valid;
      s1_a_sign <= IN1[N-1];
      s1_a_zero <= (IN1 == '0);
      s1_a_nar  <= (IN1 == NAR);
      s1_a_mag  <= IN1[N-1] ? -IN1[N-2:0] : IN1[N-2:0];
      s1_b_sign <= IN2[N-1];
      s1_b_zero <= (IN2 == '0);
      s1_b_nar  <= (IN2 == NAR);
      s1_b_mag  <= IN2[N-1] ? -IN2[N-2:0] : IN2[N-2:0];
    end
  end

  // Zero and NaR carry no scale/fraction; forcing them to 0 keeps the core's view clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      A_sign    <= 1'b0;
      A_zero    <= 1'b0;
      A_nar     <= 1'b0;
      A_scale   <= '0;
      A_frac    <= '0;
      B_sign    <= 1'b0;
      B_zero    <= 1'b0;
      B_nar     <= 1'b0;
      B_scale   <= '0;
      B_frac    <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      A_sign    <= s1_a_sign;
      A_zero    <= s1_a_zero;
      A_nar     <= s1_a_nar;
      B_sign    <= s1_b_sign;
      B_zero    <= s1_b_zero;
      B_nar     <= s1_b_nar;
      if (s1_a_zero || s1_a_nar) begin
        A_scale <= '0;
        A_frac  <= '0;
      end else begin
        {A_scale, A_frac} <= dec_a;
      end
      if (s1_b_zero || s1_b_nar) begin
        B_scale <= '0;
        B_frac  <= '0;
      end else begin
        {B_scale, B_frac} <= dec_b;
      end
    end
  end

endmodule

// File: tb/tb_posit_operand_decoder.sv
// Randomized scoreboard bench for posit_operand_decoder; expectations come from a
// bit-serial posit reader and a pipeline occupancy model.
module tb_posit_operand_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] IN1 = '0;
  logic [31:0] IN2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        A_sign, B_sign, A_zero, B_zero, A_nar, B_nar;
  logic [7:0]  A_scale, B_scale;
  logic [27:0] A_frac, B_frac;

  posit_operand_decoder #(.N(32), .ES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .IN1(IN1), .IN2(IN2), .out_valid(out_valid), .out_ready(out_ready),
    .A_sign(A_sign), .B_sign(B_sign), .A_zero(A_zero), .B_zero(B_zero),
    .A_nar(A_nar), .B_nar(B_nar), .A_scale(A_scale), .B_scale(B_scale),
    .A_frac(A_frac), .B_frac(B_frac)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] a;
    logic [38:0] b;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Reads the posit one bit at a time, MSB first, as the format is defined.
  function automatic logic [38:0] ref_dec(input logic [31:0] w);
    logic [31:0] mag;
    logic        first;
    int          pos, m, k, e, fr, sc;
    if (w == 32'h0) return {w[31], 1'b1, 1'b0, 36'd0};
    if (w == 32'h80000000) return {1'b1, 1'b0, 1'b1, 36'd0};
    mag   = w[31] ? -w : w;
    pos   = 30;
    first = mag[30];
    m     = 0;
    while (pos >= 0 && mag[pos] == first) begin
      m++;
      pos--;
    end
    pos--;
    k = first ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(mag[pos]) : 0);
      pos--;
    end
    fr = 1;
    for (int j = 0; j < 27; j++) begin
      fr = fr * 2 + ((pos >= 0) ? int'(mag[pos]) : 0);
      pos--;
    end
    sc = k * 4 + e;
    return {w[31], 2'b00, sc[7:0], fr[27:0]};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h00000001;
      4:       return 32'hFFFFFFFF;
      5:       return $urandom() >> $urandom_range(0, 31);
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy);
    exp_t e;
    bit   fin, fout, vis;
    fin  = 1'b0;
    fout = 1'b0;
    reset = rst; in_valid = v; IN1 = a; IN2 = b; out_ready = ordy;
    #1;
    if (!rst) begin
      vis = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      check("out_valid", 64'(out_valid), 64'(vis));
      check("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
      if (vis && out_valid) begin
        check("A_data", 64'({A_sign, A_zero, A_nar, A_scale, A_frac}), 64'(q[0].a));
        check("B_data", 64'({B_sign, B_zero, B_nar, B_scale, B_frac}), 64'(q[0].b));
      end
      fout = vis && ordy;
      fin  = v && ((q.size() < 2) || ordy);
    end
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (fout) void'(q.pop_front());
      if (fin) begin
        e.a = ref_dec(a);
        e.b = ref_dec(b);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] sa, input logic [27:0] fa,
                          input logic [7:0] sb, input logic [27:0] fb, input string tag);
    cycle(1'b0, 1'b1, a, b, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_A_scale"}, 64'(A_scale), 64'(sa));
    check({tag, "_A_frac"}, 64'(A_frac), 64'(fa));
    check({tag, "_B_scale"}, 64'(B_scale), 64'(sb));
    check({tag, "_B_frac"}, 64'(B_frac), 64'(fb));
    check({tag, "_A_sign"}, 64'(A_sign), 64'(a[31]));
  endtask

  logic [31:0] sa_vec[8], sb_vec[8];
  int          sent;
  logic        ordy, acc;

  initial begin
    @(negedge clk);
    cycle(1'b1, 1'b1, 32'h40000000, 32'h40000000, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_A_frac", 64'(A_frac), 64'd0);
    check("rst_B_scale", 64'(B_scale), 64'd0);

    directed(32'h40000000, 32'h48000000, 8'd0, 28'h8000000, 8'd1, 28'h8000000, "one_two");
    directed(32'hC0000000, 32'h44000000, 8'd0, 28'h8000000, 8'd0, 28'hC000000, "neg_one");
    directed(32'h7FFFFFFF, 32'h00000001, 8'd120, 28'h8000000, 8'h88, 28'h8000000, "extreme");
    directed(32'h00000000, 32'h80000000, 8'd0, 28'h0, 8'd0, 28'h0, "special");
    check("special_A_zero", 64'(A_zero), 64'd1);
    check("special_B_nar", 64'(B_nar), 64'd1);
    check("special_B_sign", 64'(B_sign), 64'd1);

    // Eight pairs streamed against a 1,0,0,1 out_ready pattern.
    for (int i = 0; i < 8; i++) begin
      sa_vec[i] = rnd_word();
      sb_vec[i] = rnd_word();
    end
    sent = 0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      ordy = (c % 4 == 0) || (c % 4 == 3);
      acc  = (q.size() < 2) || ordy;
      cycle(1'b0, 1'b1, sa_vec[sent], sb_vec[sent], ordy);
      if (acc) sent++;
    end
    check("stream_sent", 64'(sent), 64'd8);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("stream_drained", 64'(q.size()), 64'd0);

    // Reset with two pairs in flight and a pair offered during reset.
    cycle(1'b0, 1'b1, rnd_word(), rnd_word(), 1'b0);
    cycle(1'b0, 1'b1, rnd_word(), rnd_word(), 1'b0);
    cycle(1'b1, 1'b1, 32'h48000000, 32'h48000000, 1'b0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_A_scale", 64'(A_scale), 64'd0);
    check("mid_rst_B_frac", 64'(B_frac), 64'd0);
    directed(32'h44000000, 32'hC0000000, 8'd0, 28'hC000000, 8'd0, 28'h8000000, "post_rst");

    for (int c = 0; c < 400; c++)
      cycle(1'b0, $urandom_range(0, 3) != 0, rnd_word(), rnd_word(), $urandom_range(0, 3) != 0);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
